id_stream_sched: RTL and testbench

Scheduler that shares one identifier-recognition datapath between two character-stream requesters. Each requester offers a NUL-terminated string over a valid/ready handshake. The block grants one requester per string, round-robin, and feeds its characters into an embedded recognizer. At the terminator it reports the match statistics for that string. It sits between the two character sources and the downstream result consumer.

---
 rtl/id_pkg.sv | 18 +
 rtl/id_match_core.sv | 19 +
 rtl/id_stream_sched.sv | 79 +++++++
 tb/tb_id_stream_sched.sv | 182 ++++++++++++++++++
 4 files changed

// File: rtl/id_pkg.sv
// id_pkg: shared character classes, terminator, recognizer and scheduler encodings
package id_pkg;
  localparam logic [7:0] DIG_LO = 8'd48;
  localparam logic [7:0] DIG_HI = 8'd57;
  localparam logic [7:0] UP_LO  = 8'd65;
  localparam logic [7:0] UP_HI  = 8'd90;
  localparam logic [7:0] LO_LO  = 8'd97;
  localparam logic [7:0] LO_HI  = 8'd122;
  localparam logic [7:0] TERM   = 8'h00;
  typedef enum logic [1:0] {S0 = 2'b00, S1 = 2'b01, S2 = 2'b11} rec_t;
  typedef enum logic [1:0] {IDLE = 2'd0, STREAM = 2'd1, REPORT = 2'd2} sched_t;
  function automatic logic is_digit(input logic [7:0] c);
    return c >= DIG_LO && c <= DIG_HI;
  endfunction
  function automatic logic is_alpha(input logic [7:0] c);
    return (c >= UP_LO && c <= UP_HI) || (c >= LO_LO && c <= LO_HI);
  endfunction
endpackage

// File: rtl/id_match_core.sv
// id_match_core: identifier recognizer stepping S0/S1/S2 on each enabled character
module id_match_core
  import id_pkg::*;
(
  input  logic       clk,
  input  logic       rst_n,
  input  logic       clr,
  input  logic       en,
  input  logic [7:0] char,
  output rec_t       state,
  output rec_t       next_state
);
  always_comb
    next_state = is_alpha(char) ? S1 : (is_digit(char) && state != S0) ? S2 : S0;
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) state <= S0;
    else if (clr) state <= S0;
    else if (en) state <= next_state;
endmodule

// File: rtl/id_stream_sched.sv
// id_stream_sched: round-robin scheduler feeding two NUL-terminated char streams into one recognizer
module id_stream_sched
  import id_pkg::*;
#(
  parameter int CNT_W = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             req0_valid,
  input  logic [7:0]       req0_char,
  output logic             req0_ready,
  input  logic             req1_valid,
  input  logic [7:0]       req1_char,
  output logic             req1_ready,
  output logic             res_valid,
  output logic             res_id,
  output logic [CNT_W-1:0] res_hits,
  output logic             res_last_match,
  output logic             busy
);
  sched_t st;
  logic grant, pref, g_valid;
  logic [7:0] g_char;
  logic [CNT_W-1:0] hits;
  rec_t rs, rn;
  assign g_valid = grant ? req1_valid : req0_valid;
  assign g_char = grant ? req1_char : req0_char;
  assign req0_ready = st == STREAM && !grant;
  assign req1_ready = st == STREAM && grant;
  assign busy = st != IDLE;
  id_match_core u_core (
    .clk(clk),
    .rst_n(rst_n),
    .clr(st == IDLE),
    .en(st == STREAM && g_valid && g_char != TERM),
    .char(g_char),
    .state(rs),
    .next_state(rn)
  );
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      st <= IDLE;
      grant <= 1'b0;
      pref <= 1'b0;
      hits <= '0;
      res_valid <= 1'b0;
      res_id <= 1'b0;
      res_hits <= '0;
      res_last_match <= 1'b0;
    end else begin
      res_valid <= 1'b0;
      res_id <= 1'b0;
      res_hits <= '0;
      res_last_match <= 1'b0;
      case (st)
        IDLE:
          if (req0_valid || req1_valid) begin
            grant <= (req0_valid && req1_valid) ? pref : req1_valid;
            hits <= '0;
            st <= STREAM;
          end
        STREAM:
          if (g_valid) begin
            if (g_char == TERM) begin
              res_valid <= 1'b1;
              res_id <= grant;
              res_hits <= hits;
              res_last_match <= rs == S2;
              st <= REPORT;
            end else if (rn == S2 && hits != '1) hits <= hits + 1'b1;
          end
        REPORT: begin
          pref <= ~grant;
          st <= IDLE;
        end
        default: st <= IDLE;
      endcase
    end
endmodule

// File: tb/tb_id_stream_sched.sv
// tb_id_stream_sched: table-driven and scoreboard bench for id_stream_sched
module tb_id_stream_sched;
  typedef struct { bit id; int hits; bit lm; } exp_t;
  typedef struct { bit id; string s; int hits; bit lm; } vec_t;
  logic clk = 0, rst_n = 0;
  logic r0v = 0, r1v = 0, d2v = 0, d2v1 = 0;
  logic [7:0] r0c = 0, r1c = 0, d2c = 0, d2c1 = 0;
  logic r0r, r1r, rv, rid, rlm, busy;
  logic [7:0] rh;
  logic d2r0, d2r1, d2rv, d2rid, d2lm, d2busy;
  logic [1:0] d2rh;
  int errors = 0, checks = 0;
  exp_t sb[$], sb2[$], e1, e2;
  vec_t tbl[7];
  always #5 clk = ~clk;

  id_stream_sched #(.CNT_W(8)) dut (
    .clk(clk), .rst_n(rst_n),
    .req0_valid(r0v), .req0_char(r0c), .req0_ready(r0r),
    .req1_valid(r1v), .req1_char(r1c), .req1_ready(r1r),
    .res_valid(rv), .res_id(rid), .res_hits(rh), .res_last_match(rlm), .busy(busy)
  );
  id_stream_sched #(.CNT_W(2)) dut2 (
    .clk(clk), .rst_n(rst_n),
    .req0_valid(d2v), .req0_char(d2c), .req0_ready(d2r0),
    .req1_valid(d2v1), .req1_char(d2c1), .req1_ready(d2r1),
    .res_valid(d2rv), .res_id(d2rid), .res_hits(d2rh), .res_last_match(d2lm), .busy(d2busy)
  );

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  always @(negedge clk)
    if (rst_n) begin
      if (rv) begin
        if (sb.size() == 0) chk("unexpected_res", 1, 0);
        else begin
          e1 = sb.pop_front();
          chk("res_id", int'(rid), int'(e1.id));
          chk("res_hits", int'(rh), e1.hits);
          chk("res_last_match", int'(rlm), int'(e1.lm));
        end
      end else chk("res_idle_zero", int'({rid, rh, rlm}), 0);
    end

  always @(negedge clk)
    if (rst_n) begin
      if (d2rv) begin
        if (sb2.size() == 0) chk("unexpected_res2", 1, 0);
        else begin
          e2 = sb2.pop_front();
          chk("res2_id", int'(d2rid), int'(e2.id));
          chk("res2_hits", int'(d2rh), e2.hits);
          chk("res2_last_match", int'(d2lm), int'(e2.lm));
        end
      end else chk("res2_idle_zero", int'({d2rid, d2rh, d2lm}), 0);
    end

  function automatic logic rdy(input int who);
    return who == 0 ? r0r : who == 1 ? r1r : d2r0;
  endfunction

  task automatic drive(input int who, input logic v, input logic [7:0] c);
    if (who == 0) begin r0v = v; r0c = c; end
    else if (who == 1) begin r1v = v; r1c = c; end
    else begin d2v = v; d2c = c; end
  endtask

  task automatic send(input int who, input string s, input bit term, output int w0);
    int n;
    int w;
    logic [7:0] c;
    n = s.len() + (term ? 1 : 0);
    w0 = 0;
    for (int i = 0; i < n; i++) begin
      c = (i < s.len()) ? s[i] : 8'h00;
      drive(who, 1'b1, c);
      w = 0;
      forever begin
        @(negedge clk);
        if (rdy(who)) break;
        w++;
        if (w > 40) begin
          chk("ready_timeout", 0, 1);
          drive(who, 1'b0, 8'h00);
          return;
        end
      end
      if (i == 0) w0 = w;
      @(posedge clk);
      #1;
    end
    drive(who, 1'b0, 8'h00);
    if (term) begin
      @(negedge clk);
      chk("res_latency", int'(who == 2 ? d2rv : rv), 1);
    end
  endtask

  task automatic wait_idle();
    for (int k = 0; k < 20 && (busy || d2busy); k++) @(negedge clk);
    chk("idle_timeout", int'(busy | d2busy), 0);
  endtask

  initial begin
    int w;
    bit leak, r0_done;
    tbl[0] = '{1'b0, "ab12", 2, 1'b1};
    tbl[1] = '{1'b1, "Z9_9", 1, 1'b0};
    tbl[2] = '{1'b1, "a123", 3, 1'b1};
    tbl[3] = '{1'b0, "1a", 0, 1'b0};
    tbl[4] = '{1'b0, "x{9", 0, 1'b0};
    tbl[5] = '{1'b1, "Az9:", 1, 1'b0};
    tbl[6] = '{1'b0, "Q0Z9", 2, 1'b1};
    repeat (2) @(negedge clk);
    chk("reset_outputs", int'({r0r, r1r, rv, rid, rh, rlm, busy}), 0);
    chk("reset_outputs2", int'({d2r0, d2r1, d2rv, d2rid, d2rh, d2lm, d2busy}), 0);
    rst_n = 1;
    @(negedge clk);
    for (int i = 0; i < 7; i++) begin
      wait_idle();
      chk("ready_before_grant", int'(rdy(int'(tbl[i].id))), 0);
      sb.push_back('{tbl[i].id, tbl[i].hits, tbl[i].lm});
      send(int'(tbl[i].id), tbl[i].s, 1'b1, w);
      chk("grant_latency", w, 0);
    end
    wait_idle();
    sb.push_back('{1'b0, 1, 1'b0});
    send(0, "a1", 1'b0, w);
    repeat (3) begin
      @(negedge clk);
      chk("gap_ready", int'(r0r), 1);
      chk("gap_busy", int'(busy), 1);
    end
    send(0, "b", 1'b1, w);
    wait_idle();
    sb.push_back('{1'b1, 0, 1'b0});
    send(1, "", 1'b1, w);
    wait_idle();
    sb.push_back('{1'b0, 1, 1'b1});
    sb.push_back('{1'b1, 0, 1'b0});
    leak = 0;
    r0_done = 0;
    fork
      begin send(0, "x9", 1'b1, w); r0_done = 1; end
      begin int w1; send(1, "7a", 1'b1, w1); end
      while (!r0_done) begin
        @(negedge clk);
        if (r1r && !r0_done) leak = 1;
      end
    join
    chk("r1_ready_leak", int'(leak), 0);
    wait_idle();
    sb2.push_back('{1'b0, 3, 1'b1});
    send(2, "a12345", 1'b1, w);
    wait_idle();
    send(0, "ab", 1'b0, w);
    r0v = 1;
    r0c = "1";
    #2 rst_n = 0;
    @(negedge clk);
    chk("abort_outputs", int'({r0r, r1r, rv, rid, rh, rlm, busy}), 0);
    r0v = 0;
    r0c = 0;
    repeat (2) @(negedge clk);
    rst_n = 1;
    repeat (3) @(negedge clk);
    chk("abort_idle", int'({busy, rv}), 0);
    sb.push_back('{1'b1, 1, 1'b1});
    send(1, "k8", 1'b1, w);
    wait_idle();
    repeat (2) @(negedge clk);
    chk("sb_empty", sb.size() + sb2.size(), 0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
